// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared parameters, state encoding and small helpers for the instruction fetch controller.
// The FC_* names mirror the encodings the rest of the CPU uses for the fetch state.
package imem_fetch_ctrl_pkg;

    localparam int FC_ADDR_W     = 8;
    localparam int FC_DATA_W     = 8;
    localparam int FC_MEM_DEPTH  = 32;
    localparam int FC_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        FC_IDLE  = 2'd0,
        FC_FETCH = 2'd1,
        FC_DRAIN = 2'd2,
        FC_DONE  = 2'd3
    } fc_state_t;

    function automatic logic fc_is_busy(input fc_state_t s);
        return (s == FC_FETCH) || (s == FC_DRAIN);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_fifo.sv
// Synchronous prefetch FIFO with flush; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Read data is forced to zero whenever the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the combinational instruction ROM: owns the PC, prefetches
// {pc, instruction} pairs into a small FIFO and hands them to the decoder.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W     = FC_ADDR_W,
    parameter int DATA_W     = FC_DATA_W,
    parameter int MEM_DEPTH  = FC_MEM_DEPTH,
    parameter int FIFO_DEPTH = FC_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              halt,
    output logic [ADDR_W-1:0] Read_Address,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int                ENTRY_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0]   MEM_END = (ADDR_W + 1)'(MEM_DEPTH);

    fc_state_t           state;
    fc_state_t           state_next;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_next;
    logic                push;
    logic                flush;
    logic                pop;
    logic                pc_in_range;
    logic                redirect_in_range;
    logic [ENTRY_W-1:0]  fifo_rd_data;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    assign pop               = inst_valid && inst_ready;
    assign pc_in_range       = ({1'b0, pc} < MEM_END);
    assign redirect_in_range = ({1'b0, redirect_pc} < MEM_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FC_IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Redirect outranks both push and start; a redirect that lands outside program
    // memory, or coincides with halt, parks in DRAIN so the FIFO can settle to DONE.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;

        case (state)
            FC_IDLE: begin
                if (start) begin
                    state_next = FC_FETCH;
                    pc_next    = start_pc;
                end
            end

            FC_FETCH: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                    if (halt || !redirect_in_range) begin
                        state_next = FC_DRAIN;
                    end
                end else if (halt || !pc_in_range) begin
                    state_next = FC_DRAIN;
                end else if (!fifo_full || pop) begin
                    push    = 1'b1;
                    pc_next = pc + ADDR_W'(1);
                end
            end

            FC_DRAIN: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                    if (redirect_in_range && !halt) begin
                        state_next = FC_FETCH;
                    end
                end else if (fifo_empty) begin
                    state_next = FC_DONE;
                end
            end

            FC_DONE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    pc_next    = redirect_pc;
                    state_next = (redirect_in_range && !halt) ? FC_FETCH : FC_DRAIN;
                end else if (start) begin
                    state_next = FC_FETCH;
                    pc_next    = start_pc;
                end
            end

            default: begin
                state_next = FC_IDLE;
            end
        endcase
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data ({pc, instruction}),
        .pop     (pop),
        .flush   (flush),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign Read_Address = pc;
    assign inst_valid   = !fifo_empty;
    assign inst_out     = fifo_rd_data[DATA_W-1:0];
    assign inst_pc      = fifo_rd_data[ENTRY_W-1:DATA_W];
    assign busy         = fc_is_busy(state);
    assign done         = (state == FC_DONE);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a 12-byte program image.
module tb_imem_fetch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_pc;
    logic       halt;
    logic [7:0] Read_Address;
    logic [7:0] instruction;
    logic [7:0] inst_out;
    logic [7:0] inst_pc;
    logic       inst_valid;
    logic       inst_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       busy;
    logic       done;

    logic [7:0]  rom [256];
    logic [15:0] acc_q [$];
    int          checks;
    int          errors;

    imem_fetch_ctrl #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .MEM_DEPTH  (12),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_pc     (start_pc),
        .halt         (halt),
        .Read_Address (Read_Address),
        .instruction  (instruction),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .busy         (busy),
        .done         (done)
    );

    assign instruction = rom[Read_Address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record a handshake that will complete at the coming edge, then step past that edge.
    task automatic cycle();
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            acc_q.push_back({inst_pc, inst_out});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Read_Address, inst_out, inst_pc, inst_valid, busy, done} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL reset_init: outputs=%h required 0", {Read_Address, inst_out, inst_pc, inst_valid, busy, done});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        start = 1'b1; start_pc = 8'd0; inst_ready = 1'b0;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || Read_Address !== 8'd2) begin
            errors++;
            $display("[TB] FAIL reset_prefill: valid=%b addr=%0d required 1/2", inst_valid, Read_Address);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Read_Address, inst_out, inst_pc, inst_valid, busy, done} !== 27'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: outputs=%h required 0", {Read_Address, inst_out, inst_pc, inst_valid, busy, done});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Read_Address !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy=%b done=%b addr=%0d required 0/0/0", busy, done, Read_Address);
        end
    endtask

    task automatic test_streaming();
        acc_q.delete();
        inst_ready = 1'b1;
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || inst_valid !== 1'b0 || Read_Address !== 8'd0) begin
            errors++;
            $display("[TB] FAIL stream_start: busy=%b valid=%b addr=%0d required 1/0/0", busy, inst_valid, Read_Address);
        end
        cycle();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 8'd0 || inst_out !== 8'h41) begin
            errors++;
            $display("[TB] FAIL stream_first: valid=%b pc=%0d inst=%h required 1/0/41", inst_valid, inst_pc, inst_out);
        end
        run_until_done(40);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stream_done: done=%b busy=%b required 1/0", done, busy);
        end
        checks++;
        if (acc_q.size() != 12) begin
            errors++;
            $display("[TB] FAIL stream_count: got %0d required 12", acc_q.size());
        end
        for (int i = 0; i < acc_q.size() && i < 12; i++) begin
            checks++;
            if (acc_q[i] !== {8'(i), rom[i]}) begin
                errors++;
                $display("[TB] FAIL stream_entry%0d: got %h required %h", i, acc_q[i], {8'(i), rom[i]});
            end
        end
    endtask

    task automatic test_backpressure();
        acc_q.delete();
        inst_ready = 1'b0;
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (inst_valid !== 1'b1 || inst_out !== 8'h41 || inst_pc !== 8'd0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: valid=%b pc=%0d inst=%h required 1/0/41", i, inst_valid, inst_pc, inst_out);
            end
        end
        checks++;
        if (Read_Address !== 8'd2) begin
            errors++;
            $display("[TB] FAIL bp_pc_stall: addr=%0d required 2", Read_Address);
        end
        inst_ready = 1'b1;
        run_until_done(40);
        checks++;
        if (acc_q.size() != 12 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d done=%b required 12/1", acc_q.size(), done);
        end
        for (int i = 0; i < acc_q.size() && i < 12; i++) begin
            checks++;
            if (acc_q[i] !== {8'(i), rom[i]}) begin
                errors++;
                $display("[TB] FAIL bp_entry%0d: got %h required %h", i, acc_q[i], {8'(i), rom[i]});
            end
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b0;
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        cycle();
        cycle();
        inst_ready = 1'b1;
        cycle();
        cycle();
        inst_ready = 1'b0;
        cycle();
        checks++;
        if (inst_pc !== 8'd2 || Read_Address !== 8'd4) begin
            errors++;
            $display("[TB] FAIL redir_setup: head_pc=%0d addr=%0d required 2/4", inst_pc, Read_Address);
        end
        acc_q.delete();
        redirect = 1'b1; redirect_pc = 8'd9;
        cycle();
        redirect = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || Read_Address !== 8'd9 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL redir_flush: valid=%b addr=%0d busy=%b required 0/9/1", inst_valid, Read_Address, busy);
        end
        inst_ready = 1'b1;
        run_until_done(40);
        checks++;
        if (acc_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL redir_count: got %0d required 3", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== 16'h096D || acc_q[1] !== 16'h0A0C || acc_q[2] !== 16'h0BC2) begin
                errors++;
                $display("[TB] FAIL redir_seq: got %h %h %h required 096d 0a0c 0bc2", acc_q[0], acc_q[1], acc_q[2]);
            end
        end
    endtask

    task automatic test_edge_cases();
        // Out-of-range redirect while fetching.
        acc_q.delete();
        inst_ready = 1'b0;
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        cycle();
        redirect = 1'b1; redirect_pc = 8'd40;
        cycle();
        redirect = 1'b0;
        inst_ready = 1'b1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || inst_valid !== 1'b0 || Read_Address !== 8'd40) begin
            errors++;
            $display("[TB] FAIL redir40_drain: busy=%b done=%b valid=%b addr=%0d required 1/0/0/40", busy, done, inst_valid, Read_Address);
        end
        cycle();
        checks++;
        if (done !== 1'b1 || acc_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL redir40_done: done=%b pops=%0d required 1/0", done, acc_q.size());
        end

        // Halt and redirect together.
        inst_ready = 1'b0;
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        cycle();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 8'd5;
        cycle();
        halt = 1'b0; redirect = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || Read_Address !== 8'd5 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL halt_redir: valid=%b addr=%0d busy=%b required 0/5/1", inst_valid, Read_Address, busy);
        end
        cycle();
        cycle();
        checks++;
        if (done !== 1'b1 || Read_Address !== 8'd5 || inst_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_nofetch: done=%b addr=%0d valid=%b required 1/5/0", done, Read_Address, inst_valid);
        end

        // Start while already fetching.
        acc_q.delete();
        start = 1'b1; start_pc = 8'd0;
        cycle();
        start = 1'b0;
        cycle();
        start = 1'b1; start_pc = 8'd7;
        cycle();
        start = 1'b0;
        checks++;
        if (Read_Address !== 8'd2 || inst_pc !== 8'd0) begin
            errors++;
            $display("[TB] FAIL start_ignored: addr=%0d head_pc=%0d required 2/0", Read_Address, inst_pc);
        end
        inst_ready = 1'b1;
        run_until_done(40);
        checks++;
        if (acc_q.size() != 12 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_ignored_count: got %0d done=%b required 12/1", acc_q.size(), done);
        end
    endtask

    task automatic test_restart();
        acc_q.delete();
        inst_ready = 1'b1;
        start = 1'b1; start_pc = 8'd3;
        cycle();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_state: busy=%b done=%b required 1/0", busy, done);
        end
        run_until_done(40);
        checks++;
        if (acc_q.size() != 9) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d required 9", acc_q.size());
        end else begin
            checks++;
            if (acc_q[0] !== 16'h0359) begin
                errors++;
                $display("[TB] FAIL restart_first: got %h required 0359", acc_q[0]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'h00;
        end
        rom[0] = 8'h41; rom[1] = 8'hC1; rom[2]  = 8'hC1; rom[3]  = 8'h59;
        rom[4] = 8'h12; rom[5] = 8'h34; rom[6]  = 8'h56; rom[7]  = 8'h78;
        rom[8] = 8'h9A; rom[9] = 8'h6D; rom[10] = 8'h0C; rom[11] = 8'hC2;
        start = 1'b0; start_pc = 8'd0; halt = 1'b0;
        inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_edge_cases();
        test_restart();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
